// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg: shared constants and load-state encoding for the instruction ROM
package inst_rom_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0013;
    typedef enum logic {ST_IDLE, ST_LOAD} state_e;
endpackage

// File: rtl/inst_rom_if.sv
// inst_rom_if: fetch read port plus byte-serial image load port
interface inst_rom_if import inst_rom_pkg::*; #(parameter int DEPTH_LOG2 = 10);
    logic [XLEN-1:0]     rom_addr;
    logic [XLEN-1:0]     rom_data;
    logic                load_start;
    logic                load_end;
    logic                load_valid;
    logic [7:0]          load_byte;
    logic                load_ready;
    logic                load_busy;
    logic [DEPTH_LOG2:0] load_words;
    logic                load_ovf;
    modport master (
        output rom_addr, load_start, load_end, load_valid, load_byte,
        input  rom_data, load_ready, load_busy, load_words, load_ovf
    );
    modport slave (
        input  rom_addr, load_start, load_end, load_valid, load_byte,
        output rom_data, load_ready, load_busy, load_words, load_ovf
    );
endinterface

// File: rtl/inst_rom_byte_packer.sv
// rom_byte_packer: assembles little-endian bytes into words and strobes each complete or flushed word
module rom_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic        i_flush,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_we
);
    logic [1:0]  r_lane;
    logic [31:0] r_asm;

    // Merge the incoming byte into its lane; a byte arriving with a flush is included before the write
    always_comb begin
        o_word = i_accept ? (r_asm | (32'(i_byte) << {r_lane, 3'b000})) : r_asm;
        o_we   = i_accept ? (r_lane == 2'd3 || i_flush) : (i_flush && r_lane != 2'd0);
    end

    // Lane counter and assembly register; cleared whenever a word leaves or a load restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_asm  <= '0;
        end else if (i_clear || o_we) begin
            r_lane <= 2'd0;
            r_asm  <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= o_word;
        end
    end
endmodule

// File: rtl/inst_rom.sv
// inst_rom: registered instruction memory with a byte-serial image loader
module inst_rom import inst_rom_pkg::*; #(
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [XLEN-1:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    inst_rom_if.slave  bus
);
    state_e              r_state;
    state_e              w_next;
    logic [DEPTH_LOG2:0] r_words;
    logic                r_ovf;
    logic [XLEN-1:0]     r_rom_data;
    logic [31:0]         r_mem [2**DEPTH_LOG2];
    logic                w_ready;
    logic                w_busy;
    logic                w_full;
    logic                w_accept;
    logic                w_flush;
    logic                w_we;
    logic [31:0]         w_word;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                w_oob;

    assign w_full   = r_words[DEPTH_LOG2];
    assign w_accept = w_ready && bus.load_valid && !bus.load_start;
    assign w_flush  = w_busy && bus.load_end && !bus.load_start;
    assign w_idx    = bus.rom_addr[DEPTH_LOG2+1:2];
    assign w_oob    = |(bus.rom_addr >> (DEPTH_LOG2 + 2));

    rom_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (bus.load_start),
        .i_accept (w_accept),
        .i_flush  (w_flush),
        .i_byte   (bus.load_byte),
        .o_word   (w_word),
        .o_we     (w_we)
    );

    // Load state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Start always (re)enters LOAD and wins over a simultaneous end
    always_comb begin
        w_next = r_state;
        if (bus.load_start)                           w_next = ST_LOAD;
        else if (r_state == ST_LOAD && bus.load_end) w_next = ST_IDLE;
    end

    // Handshake outputs decoded from state and fullness
    always_comb begin
        w_busy  = (r_state == ST_LOAD);
        w_ready = w_busy && !w_full;
    end

    // Word counter doubles as write pointer; its top bit marks a full memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_words <= '0;
        else if (bus.load_start) r_words <= '0;
        else if (w_we)           r_words <= r_words + 1'b1;
    end

    // Sticky overflow: any byte offered while full is dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    r_ovf <= 1'b0;
        else if (bus.load_start)                    r_ovf <= 1'b0;
        else if (w_busy && bus.load_valid && w_full) r_ovf <= 1'b1;
    end

    // Memory array is deliberately unreset so the image survives core resets
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_words[DEPTH_LOG2-1:0]] <= w_word;
    end

    // Registered read; sees pre-write contents when the same word is written this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rom_data <= '0;
        else     r_rom_data <= w_oob ? NOP_WORD : r_mem[w_idx];
    end

    assign bus.rom_data   = r_rom_data;
    assign bus.load_ready = w_ready;
    assign bus.load_busy  = w_busy;
    assign bus.load_words = r_words;
    assign bus.load_ovf   = r_ovf;
endmodule
